nios_cpu_jtag_cmd_sync: RTL and testbench

Parametrised system-clock-side command synchroniser for the Nios II JTAG debug path. It replaces the fixed 2-bit-IR / 38-bit-DR sysclk capture logic. It takes the TCK-domain update strobes, scan register and IR, and turns each DR update into a registered command word with a valid/ready handshake toward the OCI debug logic. It also provides per-instruction one-hot action/no-action pulses, IR-update notification, sticky overrun detection and a command counter.

---
 rtl/nios_cpu_jtag_cmd_sync.sv | 112 +++++++++++
 tb/tb_nios_cpu_jtag_cmd_sync.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_jtag_cmd_sync.sv
// System-clock side of the JTAG debug command path: synchronises TCK-domain
// update strobes and turns each DR update into a valid/ready command word.
module nios_cpu_jtag_cmd_sync #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int ACT_BIT     = 35,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  localparam int N_CMD      = 2 ** IR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DR_W-1:0]   sr,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [DR_W-1:0]   jdo,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [N_CMD-1:0]  take_action,
  output logic [N_CMD-1:0]  take_no_action,
  output logic              ir_update,
  output logic [IR_W-1:0]   ir_q,
  output logic              overrun,
  output logic [CNT_W-1:0]  cmd_count
);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_prev, uir_prev;
  logic                   udr_rise, uir_rise;
  logic                   fire, load, drop;
  logic                   ir_update_q;

  // Chains reset to all-ones so a strobe already high at reset release is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync <= '1;
      uir_sync <= '1;
      udr_prev <= 1'b1;
      uir_prev <= 1'b1;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_prev <= udr_sync[SYNC_STAGES-1];
      uir_prev <= uir_sync[SYNC_STAGES-1];
    end
  end

  assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_prev;
  assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_prev;

  // Handshake: a command transfers on any cycle with cmd_valid & cmd_ready;
  // cmd_valid never drops without a transfer, and a new DR update arriving
  // in the transfer cycle replaces the departing command (back-to-back).
  assign fire = cmd_valid & cmd_ready & ~reset;
  assign load = udr_rise & (~cmd_valid | cmd_ready);
  assign drop = udr_rise & cmd_valid & ~cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (load) state_d = ST_PENDING;
      ST_PENDING: if (!load && fire) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state_q == ST_PENDING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jdo         <= '0;
      cmd_ir      <= '0;
      ir_q        <= '0;
      overrun     <= 1'b0;
      cmd_count   <= '0;
      ir_update_q <= 1'b0;
    end else begin
      if (load) begin
        jdo    <= sr;
        cmd_ir <= ir_in;
      end
      if (drop) overrun <= 1'b1;
      if (fire) cmd_count <= cmd_count + 1'b1;
      ir_update_q <= uir_rise;
      if (uir_rise) ir_q <= ir_in;
    end
  end

  assign ir_update = ir_update_q & ~reset;

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (fire) begin
      if (jdo[ACT_BIT]) take_action[cmd_ir]    = 1'b1;
      else              take_no_action[cmd_ir] = 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_cpu_jtag_cmd_sync.sv
// Bench for nios_cpu_jtag_cmd_sync: directed scenarios plus random traffic
// checked every cycle against an event-scheduled behavioural model.
module tb_nios_cpu_jtag_cmd_sync;

  localparam int IR_W = 2;
  localparam int DR_W = 38;
  localparam int ACT  = 35;
  localparam int S    = 2;
  localparam int CW   = 8;
  localparam int N    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [IR_W-1:0] ir_in;
  logic [DR_W-1:0] sr;
  logic            vs_udr, vs_uir, cmd_ready;
  logic            cmd_valid;
  logic [DR_W-1:0] jdo;
  logic [IR_W-1:0] cmd_ir;
  logic [N-1:0]    take_action, take_no_action;
  logic            ir_update;
  logic [IR_W-1:0] ir_q;
  logic            overrun;
  logic [CW-1:0]   cmd_count;

  nios_cpu_jtag_cmd_sync #(
    .IR_W(IR_W), .DR_W(DR_W), .ACT_BIT(ACT), .SYNC_STAGES(S), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .jdo(jdo), .cmd_ir(cmd_ir),
    .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .ir_q(ir_q), .overrun(overrun),
    .cmd_count(cmd_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: committed state plus queues of scheduled strobe events
  logic            m_valid, m_ovr, m_irupd;
  logic [DR_W-1:0] m_jdo;
  logic [IR_W-1:0] m_ir, m_irq;
  logic [CW-1:0]   m_cnt;
  int              edge_n;
  logic            last_udr, last_uir;
  int              udr_due[$];
  logic [DR_W-1:0] udr_sr[$];
  logic [IR_W-1:0] udr_ir[$];
  int              uir_due[$];
  logic [IR_W-1:0] uir_ir[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_valid = 1'b0; m_ovr = 1'b0; m_irupd = 1'b0;
    m_jdo = '0; m_ir = '0; m_irq = '0; m_cnt = '0;
    udr_due.delete(); udr_sr.delete(); udr_ir.delete();
    uir_due.delete(); uir_ir.delete();
  endtask

  // One clock: inputs are already set at the falling edge on entry.
  task automatic cycle();
    logic fire, udr_ev, uir_ev;
    logic [N-1:0] ea, en;
    logic [DR_W-1:0] ev_sr;
    logic [IR_W-1:0] ev_ir, ev_uir;
    ev_sr = '0; ev_ir = '0; ev_uir = '0;
    if (reset) begin
      udr_due.delete(); udr_sr.delete(); udr_ir.delete();
      uir_due.delete(); uir_ir.delete();
    end else begin
      // a level rise seen at the next edge k takes effect at edge k+S
      if (vs_udr && !last_udr) begin
        udr_due.push_back(edge_n + 1 + S); udr_sr.push_back(sr); udr_ir.push_back(ir_in);
      end
      if (vs_uir && !last_uir) begin
        uir_due.push_back(edge_n + 1 + S); uir_ir.push_back(ir_in);
      end
    end
    last_udr = vs_udr;
    last_uir = vs_uir;
    udr_ev = (udr_due.size() > 0) && (udr_due[0] == edge_n + 1);
    uir_ev = (uir_due.size() > 0) && (uir_due[0] == edge_n + 1);
    fire = m_valid && cmd_ready && !reset;
    ea = '0; en = '0;
    if (fire) begin
      if (m_jdo[ACT]) ea[m_ir] = 1'b1;
      else            en[m_ir] = 1'b1;
    end
    #1;
    chk("cmd_valid", 64'(cmd_valid), 64'(m_valid));
    chk("jdo", 64'(jdo), 64'(m_jdo));
    chk("cmd_ir", 64'(cmd_ir), 64'(m_ir));
    chk("take_action", 64'(take_action), 64'(ea));
    chk("take_no_action", 64'(take_no_action), 64'(en));
    chk("ir_update", 64'(ir_update), 64'(m_irupd && !reset));
    chk("ir_q", 64'(ir_q), 64'(m_irq));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("cmd_count", 64'(cmd_count), 64'(m_cnt));
    if (udr_ev) begin
      void'(udr_due.pop_front()); ev_sr = udr_sr.pop_front(); ev_ir = udr_ir.pop_front();
    end
    if (uir_ev) begin
      void'(uir_due.pop_front()); ev_uir = uir_ir.pop_front();
    end
    @(posedge clk);
    edge_n++;
    if (reset) begin
      model_clear();
    end else begin
      if (fire) m_cnt = m_cnt + 1'b1;
      if (udr_ev) begin
        if (!m_valid || cmd_ready) begin
          m_valid = 1'b1; m_jdo = ev_sr; m_ir = ev_ir;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (fire) begin
        m_valid = 1'b0;
      end
      m_irupd = uir_ev;
      if (uir_ev) m_irq = ev_uir;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic udr_pulse(input logic [DR_W-1:0] d, input logic [IR_W-1:0] ir);
    sr = d; ir_in = ir; vs_udr = 1'b1;
    run(S + 1);
    vs_udr = 1'b0;
    run(1);
  endtask

  task automatic uir_pulse(input logic [IR_W-1:0] ir);
    ir_in = ir; vs_uir = 1'b1;
    run(S + 1);
    vs_uir = 1'b0;
    run(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(S + 2);
  endtask

  initial begin
    reset = 1'b1; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
    last_udr = 1'b0; last_uir = 1'b0; edge_n = 0;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    do_reset();
    chk("reset_valid", 64'(cmd_valid), 64'd0);
    chk("reset_count", 64'(cmd_count), 64'd0);

    // single command, consumer not ready
    udr_pulse(38'h20_0000_1234, 2'd2);
    chk("single_jdo", 64'(jdo), 64'h20_0000_1234);
    chk("single_ir", 64'(cmd_ir), 64'd2);
    chk("single_valid", 64'(cmd_valid), 64'd1);
    cmd_ready = 1'b1;
    run(1);
    cmd_ready = 1'b0;
    chk("single_count", 64'(cmd_count), 64'd1);
    chk("single_valid_drop", 64'(cmd_valid), 64'd0);
    run(2);

    // action decode with cmd_ready held
    cmd_ready = 1'b1;
    udr_pulse(38'h28_dead_beef, 2'd1);
    run(2);
    chk("action_count", 64'(cmd_count), 64'd2);
    cmd_ready = 1'b0;

    // overrun: second update dropped while first pending
    udr_pulse(38'h01_1111_1111, 2'd0);
    run(1);
    udr_pulse(38'h02_2222_2222, 2'd3);
    run(2);
    chk("ovr_jdo", 64'(jdo), 64'h01_1111_1111);
    chk("ovr_flag", 64'(overrun), 64'd1);
    run(3);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    do_reset();
    chk("ovr_reset", 64'(overrun), 64'd0);
    chk("ovr_reset_valid", 64'(cmd_valid), 64'd0);

    // back-to-back: B's load edge coincides with accepting A
    udr_pulse(38'h0A_0000_000A, 2'd1);
    run(1);
    sr = 38'h0B_0000_000B; ir_in = 2'd2; vs_udr = 1'b1;
    run(S);
    cmd_ready = 1'b1;
    run(1);
    cmd_ready = 1'b0; vs_udr = 1'b0;
    chk("b2b_jdo", 64'(jdo), 64'h0B_0000_000B);
    chk("b2b_valid", 64'(cmd_valid), 64'd1);
    chk("b2b_count", 64'(cmd_count), 64'd1);
    chk("b2b_overrun", 64'(overrun), 64'd0);
    run(1);
    cmd_ready = 1'b1;
    run(1);
    cmd_ready = 1'b0;
    run(1);

    // IR update while a command is pending
    udr_pulse(38'h00_0000_0055, 2'd0);
    uir_pulse(2'd3);
    chk("ir_q", 64'(ir_q), 64'd3);
    chk("ir_cmd_ir", 64'(cmd_ir), 64'd0);
    chk("ir_valid", 64'(cmd_valid), 64'd1);
    cmd_ready = 1'b1;
    run(1);
    cmd_ready = 1'b0;
    run(1);

    // strobe held high through reset release
    vs_udr = 1'b1;
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(S + 3);
    chk("held_no_valid", 64'(cmd_valid), 64'd0);
    vs_udr = 1'b0;
    run(S + 2);

    // random traffic: DR, IR, simultaneous, idle, random ready
    for (int it = 0; it < 60; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
      sr = DR_W'({$urandom(), $urandom()});
      ir_in = IR_W'($urandom_range(0, 3));
      if (kind == 0 || kind == 2) vs_udr = 1'b1;
      if (kind == 1 || kind == 2) vs_uir = 1'b1;
      for (int j = 0; j < S + 1; j++) begin
        cmd_ready = 1'($urandom_range(0, 1));
        cycle();
      end
      vs_udr = 1'b0; vs_uir = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        cmd_ready = 1'($urandom_range(0, 1));
        cycle();
      end
    end

    // counter wrap
    cmd_ready = 1'b1;
    run(2);
    for (int i = 0; i < 300 && m_cnt != 8'hFF; i++)
      udr_pulse(DR_W'({$urandom(), $urandom()}), IR_W'($urandom_range(0, 3)));
    chk("cnt_255", 64'(cmd_count), 64'd255);
    udr_pulse(38'h3F_FFFF_FFFF, 2'd3);
    chk("cnt_wrap", 64'(cmd_count), 64'd0);
    cmd_ready = 1'b0;
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
